// File: rtl/neuron_layer_loader.sv
`default_nettype none
// ============================================================================
// Module   : neuron_layer_loader
// Purpose  : Runtime weight/bias loader for one parallel neuron layer. Takes
//            a serial stream of words, packs NUM_NEURONS words per RAM row,
//            writes NEURON_INPUTS weight rows and then a single bias row into
//            the layer's RAM ports. The layer is held in reset while loading
//            so it picks up the new RAM contents when hold releases.
// Ports    : clk, rst              - clock, async active-high reset
//            i_load_start          - 1-cycle reload request
//            o_load_ready_in       - stream ready (high only while collecting)
//            i_load_valid_in       - stream valid
//            i_load_data_in        - stream word
//            o_weight_address/data/wren - weight RAM write port
//            o_bias_address/data/wren   - bias RAM write port (address 0)
//            o_layer_hold          - ORed into the layer's reset
//            o_load_busy           - load in progress
//            o_load_done           - 1-cycle pulse at load completion
//            o_load_error          - sticky: start requested while busy
// Revision : 1.0 - initial release
// ============================================================================
module neuron_layer_loader #(
  parameter  int DATA_WIDTH    = 32,
  parameter  int NUM_NEURONS   = 32,
  parameter  int NEURON_INPUTS = 5,
  localparam int RAM_WIDTH     = DATA_WIDTH * NUM_NEURONS,
  localparam int WA            = (NEURON_INPUTS > 1) ? $clog2(NEURON_INPUTS) : 1,
  localparam int CW            = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load_start,
  output logic                  o_load_ready_in,
  input  logic                  i_load_valid_in,
  input  logic [DATA_WIDTH-1:0] i_load_data_in,
  output logic [WA-1:0]         o_weight_address,
  output logic [RAM_WIDTH-1:0]  o_weight_data,
  output logic                  o_weight_wren,
  output logic                  o_bias_address,
  output logic [RAM_WIDTH-1:0]  o_bias_data,
  output logic                  o_bias_wren,
  output logic                  o_layer_hold,
  output logic                  o_load_busy,
  output logic                  o_load_done,
  output logic                  o_load_error
);

  localparam logic [CW-1:0] c_WORD_LAST = CW'(NUM_NEURONS - 1);
  localparam logic [WA-1:0] c_ROW_LAST  = WA'(NEURON_INPUTS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COLLECT_W = 3'd1,
    S_WRITE_W   = 3'd2,
    S_COLLECT_B = 3'd3,
    S_WRITE_B   = 3'd4,
    S_SETTLE    = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t                 r_state,  w_state_nxt;
  logic [CW-1:0]          r_word_cnt, w_word_nxt;
  logic [WA-1:0]          r_row_cnt,  w_row_nxt;
  logic                   r_settle,   w_settle_nxt;
  logic                   r_ready,    w_ready_nxt;
  logic                   r_hold,     w_hold_nxt;
  logic                   r_busy,     w_busy_nxt;
  logic                   r_done,     w_done_nxt;
  logic                   r_error,    w_error_nxt;
  logic                   r_wwren,    w_wwren_nxt;
  logic                   r_bwren,    w_bwren_nxt;
  logic [WA-1:0]          r_waddr,    w_waddr_nxt;
  logic [RAM_WIDTH-1:0]   r_wdata,    w_wdata_nxt;
  logic [RAM_WIDTH-1:0]   r_bdata,    w_bdata_nxt;

  logic                   w_accept;
  logic [RAM_WIDTH-1:0]   w_packed;

  // Ready is only ever high in the collect states, so an accept implies one.
  assign w_accept = i_load_valid_in & r_ready;

  // Row packer: the newest word enters the LSB slice, so the first word of a
  // row ends up in the MSB slice once the row is full. The oldest slice falls
  // off the top and is never stored.
  generate
    if (NUM_NEURONS > 1) begin : g_pack_shift
      localparam int PW = RAM_WIDTH - DATA_WIDTH;
      logic [PW-1:0] r_pack;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pack <= '0;
        end else if (w_accept) begin
          r_pack <= w_packed[PW-1:0];
        end
      end

      assign w_packed = {r_pack, i_load_data_in};
    end else begin : g_pack_single
      assign w_packed = i_load_data_in;
    end
  endgenerate

  // State and every output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_word_cnt <= '0;
      r_row_cnt  <= '0;
      r_settle   <= 1'b0;
      r_ready    <= 1'b0;
      r_hold     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_wwren    <= 1'b0;
      r_bwren    <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_bdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_cnt <= w_word_nxt;
      r_row_cnt  <= w_row_nxt;
      r_settle   <= w_settle_nxt;
      r_ready    <= w_ready_nxt;
      r_hold     <= w_hold_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
      r_wwren    <= w_wwren_nxt;
      r_bwren    <= w_bwren_nxt;
      r_waddr    <= w_waddr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_bdata    <= w_bdata_nxt;
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead so
  // that every port comes straight from a flop.
  always_comb begin
    w_state_nxt  = r_state;
    w_word_nxt   = r_word_cnt;
    w_row_nxt    = r_row_cnt;
    w_settle_nxt = r_settle;
    w_ready_nxt  = r_ready;
    w_hold_nxt   = r_hold;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_error_nxt  = r_error;
    w_wwren_nxt  = 1'b0;
    w_bwren_nxt  = 1'b0;
    w_waddr_nxt  = r_waddr;
    w_wdata_nxt  = r_wdata;
    w_bdata_nxt  = r_bdata;

    // Busy covers COLLECT..SETTLE; a start there is dropped and flagged.
    if (i_load_start && r_busy) begin
      w_error_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (i_load_start) begin
          w_state_nxt = S_COLLECT_W;
          w_word_nxt  = '0;
          w_row_nxt   = '0;
          w_ready_nxt = 1'b1;
          w_hold_nxt  = 1'b1;
          w_busy_nxt  = 1'b1;
          w_error_nxt = 1'b0;
        end
      end

      S_COLLECT_W, S_COLLECT_B: begin
        if (w_accept) begin
          if (r_word_cnt == c_WORD_LAST) begin
            w_word_nxt  = '0;
            w_ready_nxt = 1'b0;
            if (r_state == S_COLLECT_W) begin
              w_state_nxt = S_WRITE_W;
              w_wwren_nxt = 1'b1;
              w_waddr_nxt = r_row_cnt;
              w_wdata_nxt = w_packed;
            end else begin
              w_state_nxt = S_WRITE_B;
              w_bwren_nxt = 1'b1;
              w_bdata_nxt = w_packed;
            end
          end else begin
            w_word_nxt = r_word_cnt + CW'(1);
          end
        end
      end

      S_WRITE_W: begin
        w_ready_nxt = 1'b1;
        if (r_row_cnt == c_ROW_LAST) begin
          w_state_nxt = S_COLLECT_B;
        end else begin
          w_row_nxt   = r_row_cnt + WA'(1);
          w_state_nxt = S_COLLECT_W;
        end
      end

      S_WRITE_B: begin
        w_state_nxt  = S_SETTLE;
        w_settle_nxt = 1'b0;
      end

      // Two cycles so the RAM's registered write has landed before the
      // layer leaves reset.
      S_SETTLE: begin
        if (r_settle) begin
          w_state_nxt = S_DONE;
          w_hold_nxt  = 1'b0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_settle_nxt = 1'b1;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_load_ready_in  = r_ready;
  assign o_weight_address = r_waddr;
  assign o_weight_data    = r_wdata;
  assign o_weight_wren    = r_wwren;
  assign o_bias_address   = 1'b0;
  assign o_bias_data      = r_bdata;
  assign o_bias_wren      = r_bwren;
  assign o_layer_hold     = r_hold;
  assign o_load_busy      = r_busy;
  assign o_load_done      = r_done;
  assign o_load_error     = r_error;

endmodule
`default_nettype wire
